// File: rtl/booth_div.sv
// ---------------------------------------------------------------------------
// booth_div
//
// Sequential signed divider (N_DIVIDEND / N_DIVISOR, default 16 / 8), the
// inverse of booth_mul. It divides operand magnitudes with an unsigned
// restoring core that produces one quotient bit per clock. Signs are applied
// afterwards, so results round toward zero and the remainder takes the sign
// of the dividend, the same as Verilog '/' and '%' on signed operands.
// Out-of-range quotients saturate and raise overflow. A zero divisor skips
// the iteration phase and returns a zero result with div_by_zero set.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle
//   dividend     signed dividend, captured at the accepting edge
//   divisor      signed divisor, captured at the accepting edge
//   busy         high while a division is in progress
//   done         one-cycle pulse when the result registers update
//   quotient     signed quotient, held until the next done
//   remainder    signed remainder, held until the next done
//   div_by_zero  last result came from a zero divisor
//   overflow     last quotient did not fit and was saturated
// ---------------------------------------------------------------------------
module booth_div #(
  parameter int N_DIVIDEND = 16,
  parameter int N_DIVISOR  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_DIVIDEND-1:0] dividend,
  input  logic [N_DIVISOR-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [N_DIVISOR-1:0]  quotient,
  output logic [N_DIVISOR-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  // One iteration per dividend bit; the counter wraps exactly once per run.
  localparam int CW = $clog2(N_DIVIDEND);
  localparam logic [CW-1:0] LAST_ITER = CW'(N_DIVIDEND - 1);

  // The signed quotient needs one extra bit so the negated magnitude of the
  // most negative dividend can still be compared against the output range.
  localparam int QW = N_DIVIDEND + 1;
  localparam logic signed [QW-1:0] Q_MAX = QW'((1 << (N_DIVISOR - 1)) - 1);
  localparam logic signed [QW-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t                state;
  logic [CW-1:0]         iter_cnt;
  logic [N_DIVIDEND-1:0] q_reg;
  logic [N_DIVISOR-1:0]  p_reg;
  logic [N_DIVISOR-1:0]  dvs_mag;
  logic                  sign_q;
  logic                  sign_r;
  logic                  dbz;

  logic [N_DIVIDEND-1:0] dividend_mag;
  logic [N_DIVISOR-1:0]  divisor_mag;
  logic [N_DIVISOR:0]    p_shift;
  logic [N_DIVISOR:0]    p_diff;
  logic                  p_ge;
  logic [N_DIVISOR-1:0]  p_next;
  logic [N_DIVIDEND-1:0] q_next;
  logic [QW-1:0]         q_ext;
  logic signed [QW-1:0]  q_signed;
  logic                  q_ovf;
  logic [N_DIVISOR-1:0]  q_sat;
  logic [N_DIVISOR-1:0]  r_signed;

  // Operand magnitudes. Unary minus of the most negative value wraps back to
  // itself, which is exactly its magnitude when read as unsigned.
  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
    if (dividend[N_DIVIDEND-1]) begin
      dividend_mag = -dividend;
    end
    if (divisor[N_DIVISOR-1]) begin
      divisor_mag = -divisor;
    end
  end

  // One restoring step. The partial remainder is shifted into a 9-bit value
  // and compared with the divisor through the borrow of the subtraction: the
  // shifted value is at most 255 and the divisor at least 1, so bit 8 of the
  // difference is set exactly when the subtraction would go negative. The
  // kept remainder is always below the divisor, so 8 bits are enough to store.
  always_comb begin
    p_shift = {p_reg, q_reg[N_DIVIDEND-1]};
    p_diff  = p_shift - {1'b0, dvs_mag};
    p_ge    = ~p_diff[N_DIVISOR];
    p_next  = p_ge ? p_diff[N_DIVISOR-1:0] : p_shift[N_DIVISOR-1:0];
    q_next  = {q_reg[N_DIVIDEND-2:0], p_ge};
  end

  // Sign application and range check for the final result. The saturation
  // value follows the quotient sign; overflow only happens with a nonzero
  // magnitude, so sign_q always matches the true sign in that case.
  always_comb begin
    q_ext    = {1'b0, q_reg};
    q_signed = sign_q ? $signed(-q_ext) : $signed(q_ext);
    q_ovf    = (q_signed > Q_MAX) || (q_signed < Q_MIN);
    q_sat    = sign_q ? {1'b1, {(N_DIVISOR-1){1'b0}}}
                      : {1'b0, {(N_DIVISOR-1){1'b1}}};
    r_signed = sign_r ? -p_reg : p_reg;
  end

  // Control FSM and datapath registers. IDLE captures operands so later
  // input changes have no effect, CALC runs the iterations, and FIX writes
  // every result register and both flags together with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      iter_cnt    <= '0;
      q_reg       <= '0;
      p_reg       <= '0;
      dvs_mag     <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            q_reg    <= dividend_mag;
            p_reg    <= '0;
            dvs_mag  <= divisor_mag;
            sign_q   <= dividend[N_DIVIDEND-1] ^ divisor[N_DIVISOR-1];
            sign_r   <= dividend[N_DIVIDEND-1];
            iter_cnt <= '0;
            busy     <= 1'b1;
            if (divisor == '0) begin
              dbz   <= 1'b1;
              state <= S_FIX;
            end else begin
              dbz   <= 1'b0;
              state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          p_reg    <= p_next;
          q_reg    <= q_next;
          iter_cnt <= iter_cnt + 1'b1;
          if (iter_cnt == LAST_ITER) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          if (dbz) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (q_ovf) begin
            quotient    <= q_sat;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= q_signed[N_DIVISOR-1:0];
            remainder   <= r_signed;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_div.sv
// ---------------------------------------------------------------------------
// tb_booth_div
//
// Self-checking bench for booth_div. Expected results come from plain
// integer '/' and '%' on the signed operands, followed by the saturation and
// divide-by-zero rules. Directed vectors are followed by random operands.
// ---------------------------------------------------------------------------
module tb_booth_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int assert_count = 0;
  int fail_count   = 0;

  booth_div #(
    .N_DIVIDEND(16),
    .N_DIVISOR (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and on a miss counts and reports it
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: Verilog signed division rounds toward zero and gives
  // the remainder the dividend's sign; then apply the 8-bit output rules.
  task automatic refModel(input logic signed [15:0] a, input logic signed [7:0] b,
                          output logic [7:0] eq, output logic [7:0] er,
                          output logic edbz, output logic eovf);
    int ai, bi, qi, ri;
    ai = a;
    bi = b;
    edbz = 1'b0;
    eovf = 1'b0;
    if (bi == 0) begin
      edbz = 1'b1;
      eq   = 8'h00;
      er   = 8'h00;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      if (qi > 127) begin
        eovf = 1'b1;
        eq   = 8'h7F;
        er   = 8'h00;
      end else if (qi < -128) begin
        eovf = 1'b1;
        eq   = 8'h80;
        er   = 8'h00;
      end else begin
        eq = qi[7:0];
        er = ri[7:0];
      end
    end
  endtask

  // Runs one division: start pulse, input scrambling after acceptance,
  // an optional ignored start pulse mid-run, then latency/result/pulse checks.
  task automatic applyStimulus(input logic signed [15:0] a, input logic signed [7:0] b,
                               input bit mid_start);
    logic [7:0] eq, er;
    logic       edbz, eovf;
    int         cycles;
    refModel(a, b, eq, er, edbz, eovf);

    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    checkOutput("busy_after_accept", {15'd0, busy}, 16'd1);

    cycles = 0;
    while (!done && cycles < 40) begin
      start = (mid_start && cycles == 5) ? 1'b1 : 1'b0;
      if (mid_start && cycles == 5) begin
        dividend = 16'($urandom);
        divisor  = 8'($urandom_range(1, 255));
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;

    checkOutput("latency", 16'(cycles), (b == 8'sd0) ? 16'd1 : 16'd17);
    checkOutput("quotient", {8'd0, quotient}, {8'd0, eq});
    checkOutput("remainder", {8'd0, remainder}, {8'd0, er});
    checkOutput("div_by_zero", {15'd0, div_by_zero}, {15'd0, edbz});
    checkOutput("overflow", {15'd0, overflow}, {15'd0, eovf});
    checkOutput("busy_at_done", {15'd0, busy}, 16'd0);

    @(posedge clk);
    #1;
    checkOutput("done_width", {15'd0, done}, 16'd0);
    checkOutput("quotient_held", {8'd0, quotient}, {8'd0, eq});
    if (mid_start) begin
      repeat (3) begin
        @(posedge clk);
        #1;
        checkOutput("no_queued_start", {14'd0, busy, done}, 16'd0);
      end
    end
  endtask

  initial begin
    $display("[TB] booth_div bench starting");
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    checkOutput("reset_done", {15'd0, done}, 16'd0);
    checkOutput("reset_q_r", {quotient, remainder}, 16'd0);
    checkOutput("reset_flags", {14'd0, div_by_zero, overflow}, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Round trips of multiplier products
    applyStimulus(16'sd8395, -8'sd115, 1'b0);
    applyStimulus(-16'sd6, -8'sd2, 1'b0);
    applyStimulus(16'sd120, -8'sd10, 1'b0);

    // Sign and rounding
    applyStimulus(16'sd100, 8'sd7, 1'b0);
    applyStimulus(-16'sd100, 8'sd7, 1'b0);
    applyStimulus(16'sd100, -8'sd7, 1'b0);
    applyStimulus(-16'sd100, -8'sd7, 1'b0);

    // Boundaries
    applyStimulus(16'sd16384, -8'sd128, 1'b0);
    applyStimulus(-16'sd32768, -8'sd128, 1'b0);
    applyStimulus(-16'sd32768, 8'sd1, 1'b0);
    applyStimulus(16'sd127, 8'sd127, 1'b0);

    // Divide by zero, then a normal division clears the flag
    applyStimulus(16'sd1234, 8'sd0, 1'b0);
    applyStimulus(16'sd10, 8'sd3, 1'b0);

    // Start pulse while busy is ignored
    applyStimulus(16'sd5000, 8'sd47, 1'b1);

    // Reset during iteration 8 aborts the division
    @(negedge clk);
    dividend = 16'sd8395;
    divisor  = -8'sd115;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy_done", {14'd0, busy, done}, 16'd0);
    checkOutput("abort_q_r", {quotient, remainder}, 16'd0);
    checkOutput("abort_flags", {14'd0, div_by_zero, overflow}, 16'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_done", {15'd0, done}, 16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("after_abort_idle", {14'd0, busy, done}, 16'd0);
    end
    applyStimulus(16'sd8395, -8'sd73, 1'b0);

    // Random operands, with an occasional zero divisor
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      applyStimulus(ra, rb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
